// File: rtl/tlb_mt_pkg.sv
// Shared types for the thread-tagged TLB: page/thread field types, entry layout, default depth.
package tlb_mt_pkg;

  localparam int unsigned TLB_VPN_W = 20;
  localparam int unsigned TLB_PPN_W = 8;
  localparam int unsigned TLB_OFF_W = 12;
  localparam int unsigned TLB_TID_W = 3;

  localparam int unsigned tlb_n_entries = 8;

  typedef logic [TLB_VPN_W-1:0] vpn_t;
  typedef logic [TLB_PPN_W-1:0] ppn_t;
  typedef logic [TLB_OFF_W-1:0] page_offset_t;
  typedef logic [TLB_TID_W-1:0] threadid_t;

  typedef struct packed {
    logic      valid;
    threadid_t tid;
    vpn_t      vpn;
    ppn_t      ppn;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_mt_match.sv
// Combinational {tid, vpn} compare across all TLB entries; lowest index wins on multiple matches.
module tlb_mt_match #(
  parameter int unsigned N     = 8,
  parameter int unsigned TID_W = 3,
  parameter int unsigned VPN_W = 20,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]            valid,
  input  logic [N-1:0][TID_W-1:0] tid,
  input  logic [N-1:0][VPN_W-1:0] vpn,
  input  logic [TID_W-1:0]        key_tid,
  input  logic [VPN_W-1:0]        key_vpn,
  output logic                    hit_c,
  output logic [N-1:0]            onehot_c,
  output logic [IDX_W-1:0]        idx_c
);

  logic [N-1:0] match;

  always_comb begin
    match = '0;
    idx_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      match[i] = valid[i] && (tid[i] == key_tid) && (vpn[i] == key_vpn);
    end
    // Descending scan so the lowest matching index is the last assignment.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (match[i]) idx_c = IDX_W'(i);
    end
    onehot_c = match & (~match + N'(1));
    hit_c    = |match;
  end

endmodule

// File: rtl/tlb_mt.sv
// Fully-associative thread-tagged TLB with single-cycle registered lookup, dedup/FIFO refill and flush.
// Optional hit/miss counters are built when TLB_MT_STATS_EN is defined.
module tlb_mt
  import tlb_mt_pkg::*;
#(
  parameter int unsigned N_ENTRIES = tlb_n_entries,
  parameter int unsigned VPN_W     = $bits(vpn_t),
  parameter int unsigned PPN_W     = $bits(ppn_t),
  parameter int unsigned OFF_W     = $bits(page_offset_t),
  parameter int unsigned TID_W     = $bits(threadid_t)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lookup_valid,
  input  logic [TID_W-1:0]       lookup_tid,
  input  logic [VPN_W+OFF_W-1:0] lookup_vptr,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [TID_W-1:0]       resp_tid,
  output logic [PPN_W+OFF_W-1:0] resp_pptr,
  input  logic                   wr_en,
  input  logic [TID_W-1:0]       wr_tid,
  input  logic [VPN_W-1:0]       wr_vpn,
  input  logic [PPN_W-1:0]       wr_ppn,
  input  logic                   flush_en,
  input  logic                   flush_all,
  input  logic [TID_W-1:0]       flush_tid,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
);

  localparam int unsigned IDX_W = $clog2(N_ENTRIES);

  logic [N_ENTRIES-1:0]            valid_q;
  logic [N_ENTRIES-1:0][TID_W-1:0] tid_q;
  logic [N_ENTRIES-1:0][VPN_W-1:0] vpn_q;
  logic [N_ENTRIES-1:0][PPN_W-1:0] ppn_q;
  logic [IDX_W-1:0]                ptr_q;

  logic                 lk_hit_c;
  logic [N_ENTRIES-1:0] lk_oh_c;
  logic [IDX_W-1:0]     lk_idx_c;
  logic                 wr_hit_c;
  logic [N_ENTRIES-1:0] wr_oh_c;
  logic [IDX_W-1:0]     wr_idx_c;

  logic [N_ENTRIES-1:0] valid_flushed_c;
  logic [N_ENTRIES-1:0] valid_next_c;
  logic                 free_any_c;
  logic [IDX_W-1:0]     free_idx_c;
  logic [IDX_W-1:0]     victim_c;
  logic                 ptr_adv_c;

  // Only the index form of each match result drives datapath; one-hot vectors are spare.
  logic unused_onehot;
  assign unused_onehot = ^{lk_oh_c, wr_oh_c};

  tlb_mt_match #(
    .N(N_ENTRIES), .TID_W(TID_W), .VPN_W(VPN_W), .IDX_W(IDX_W)
  ) u_lookup_match (
    .valid    (valid_q),
    .tid      (tid_q),
    .vpn      (vpn_q),
    .key_tid  (lookup_tid),
    .key_vpn  (lookup_vptr[VPN_W+OFF_W-1:OFF_W]),
    .hit_c    (lk_hit_c),
    .onehot_c (lk_oh_c),
    .idx_c    (lk_idx_c)
  );

  // Dedup sees post-flush validity so flush-then-write ordering holds for the victim choice too.
  tlb_mt_match #(
    .N(N_ENTRIES), .TID_W(TID_W), .VPN_W(VPN_W), .IDX_W(IDX_W)
  ) u_write_match (
    .valid    (valid_flushed_c),
    .tid      (tid_q),
    .vpn      (vpn_q),
    .key_tid  (wr_tid),
    .key_vpn  (wr_vpn),
    .hit_c    (wr_hit_c),
    .onehot_c (wr_oh_c),
    .idx_c    (wr_idx_c)
  );

  // Flush, then pick the write victim: dedup entry, lowest free entry, or FIFO pointer.
  always_comb begin
    valid_flushed_c = valid_q;
    free_any_c      = 1'b0;
    free_idx_c      = '0;
    for (int i = 0; i < int'(N_ENTRIES); i++) begin
      if (flush_en && (flush_all || tid_q[i] == flush_tid)) valid_flushed_c[i] = 1'b0;
    end
    for (int i = int'(N_ENTRIES) - 1; i >= 0; i--) begin
      if (!valid_flushed_c[i]) begin
        free_any_c = 1'b1;
        free_idx_c = IDX_W'(i);
      end
    end
    ptr_adv_c = 1'b0;
    if (wr_hit_c) begin
      victim_c = wr_idx_c;
    end else if (free_any_c) begin
      victim_c = free_idx_c;
    end else begin
      victim_c  = ptr_q;
      ptr_adv_c = 1'b1;
    end
    valid_next_c = valid_flushed_c;
    if (wr_en) valid_next_c[victim_c] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_next_c;
      if (wr_en) begin
        tid_q[victim_c] <= wr_tid;
        vpn_q[victim_c] <= wr_vpn;
        ppn_q[victim_c] <= wr_ppn;
        // Depth is a power of two, so the natural wrap is modulo N_ENTRIES.
        if (ptr_adv_c) ptr_q <= ptr_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_tid   <= '0;
      resp_pptr  <= '0;
    end else begin
      resp_valid <= lookup_valid;
      if (lookup_valid) begin
        resp_hit  <= lk_hit_c;
        resp_tid  <= lookup_tid;
        resp_pptr <= lk_hit_c ? {ppn_q[lk_idx_c], lookup_vptr[OFF_W-1:0]} : '0;
      end
    end
  end

`ifdef TLB_MT_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  // Saturating counters advance with each registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (lookup_valid) begin
      if (lk_hit_c && hit_q != 32'hFFFF_FFFF) hit_q <= hit_q + 32'd1;
      if (!lk_hit_c && miss_q != 32'hFFFF_FFFF) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
